// File: rtl/stutter_pkg.sv
// Shared types and defaults for the strobe stutter monitor and its tick generators.
package stutter_pkg;

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} mon_state_t;

    localparam int STUTTER_PERIOD = 65536;

    // Width that holds PERIOD+TOL+1 without wrapping.
    function automatic int counter_width(input int period, input int tol);
        return $clog2(period + tol + 2);
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Saturating up-counter with synchronous clear and a one-cycle-early terminal compare.
module interval_counter
    import stutter_pkg::*;
#(
    parameter int CW   = 17,
    parameter int TERM = STUTTER_PERIOD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          term
);

    localparam logic [CW-1:0] TERM_M1 = CW'(TERM - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

    // term marks the cycle whose edge would complete an interval of TERM.
    assign term = (cnt == TERM_M1);

endmodule

// File: rtl/stutter_monitor.sv
// Strobe interval monitor: measures cy_in spacing, flags early/late strobes, declares lock.
// Optional error counter output is enabled with `define STUTTER_MON_ERRCNT_EN.
module stutter_monitor
    import stutter_pkg::*;
#(
    parameter int PERIOD = STUTTER_PERIOD,
    parameter int TOL    = 0,
    parameter int LOCK_N = 4,
    parameter int CW     = counter_width(PERIOD, TOL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cy_in,
    output logic          lock,
    output logic          early,
    output logic          late,
    output logic [CW-1:0] interval,
    output logic          interval_vld
`ifdef STUTTER_MON_ERRCNT_EN
    ,
    output logic [7:0]    err_cnt
`endif
);

    localparam logic [CW-1:0] LO     = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] HI     = CW'(PERIOD + TOL);
    localparam logic [3:0]    LOCK_G = 4'(LOCK_N);

    mon_state_t    state, next_state;
    logic [CW-1:0] cnt, meas;
    logic          term;
    logic [3:0]    good, good_next;
    logic          tracking, meas_good, meas_early;
    logic          early_next, late_next, vld_next;

    interval_counter #(.CW(CW), .TERM(PERIOD + TOL)) u_interval_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cy_in),
        .cnt   (cnt),
        .term  (term)
    );

    // Measurement saturates with the counter rather than wrapping to zero.
    assign meas       = (&cnt) ? cnt : cnt + CW'(1);
    assign meas_good  = (meas >= LO) && (meas <= HI);
    assign meas_early = (meas < LO);
    assign tracking   = (state == TRACK) || (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            good         <= '0;
            lock         <= 1'b0;
            early        <= 1'b0;
            late         <= 1'b0;
            interval_vld <= 1'b0;
            interval     <= '0;
        end else begin
            state        <= next_state;
            good         <= good_next;
            lock         <= (next_state == LOCKED);
            early        <= early_next;
            late         <= late_next;
            interval_vld <= vld_next;
            if (vld_next) begin
                interval <= meas;
            end
        end
    end

    always_comb begin
        next_state = state;
        good_next  = good;
        case (state)
            IDLE: begin
                if (cy_in) begin
                    next_state = TRACK;
                    good_next  = '0;
                end
            end
            TRACK, LOCKED: begin
                if (cy_in) begin
                    if (meas_good) begin
                        good_next = (good >= LOCK_G) ? LOCK_G : good + 4'd1;
                        if (good_next == LOCK_G) begin
                            next_state = LOCKED;
                        end
                    end else begin
                        // Early strobes and strobes after a late flag both break the run.
                        good_next  = '0;
                        next_state = TRACK;
                    end
                end else if (term) begin
                    good_next  = '0;
                    next_state = TRACK;
                end
            end
            default: begin
                next_state = IDLE;
                good_next  = '0;
            end
        endcase
    end

    always_comb begin
        early_next = tracking && cy_in && meas_early;
        late_next  = tracking && !cy_in && term;
        vld_next   = tracking && cy_in;
    end

`ifdef STUTTER_MON_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if ((early_next || late_next) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stutter_monitor.sv
// Self-checking bench for stutter_monitor: directed scenarios then random strobe gaps,
// checked every cycle against a timestamp-based reference model.
module tb_stutter_monitor;

    localparam int PERIOD = 8;
    localparam int TOL    = 1;
    localparam int LOCK_N = 2;
    localparam int CW     = 5;
    localparam int LO     = PERIOD - TOL;
    localparam int HI     = PERIOD + TOL;
    localparam int MAXV   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cy_in = 1'b0;
    logic          lock, early, late, interval_vld;
    logic [CW-1:0] interval;
`ifdef STUTTER_MON_ERRCNT_EN
    logic [7:0]    err_cnt;
    int            exp_err = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: time of last strobe plus a count of consecutive good intervals.
    int n = 0;
    bit have_ref = 0;
    int last_t = 0;
    int good = 0;
    bit exp_lock = 0, exp_early = 0, exp_late = 0, exp_vld = 0;
    int exp_interval = 0;

    always #5 clk = ~clk;

    stutter_monitor #(.PERIOD(PERIOD), .TOL(TOL), .LOCK_N(LOCK_N), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cy_in        (cy_in),
        .lock         (lock),
        .early        (early),
        .late         (late),
        .interval     (interval),
        .interval_vld (interval_vld)
`ifdef STUTTER_MON_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s at step %0d: observed=%0d expected=%0d", tag, n, obs, expv);
        end
    endtask

    task automatic modelStep(input logic r, input logic c);
        int elapsed;
        int meas;
        exp_early = 0;
        exp_late  = 0;
        exp_vld   = 0;
        if (!r) begin
            have_ref     = 0;
            good         = 0;
            exp_lock     = 0;
            exp_interval = 0;
`ifdef STUTTER_MON_ERRCNT_EN
            exp_err      = 0;
`endif
        end else if (!have_ref) begin
            if (c) begin
                have_ref = 1;
                last_t   = n;
            end
        end else begin
            elapsed = n - last_t;
            if (c) begin
                meas         = (elapsed > MAXV) ? MAXV : elapsed;
                exp_vld      = 1;
                exp_interval = meas;
                if (meas >= LO && meas <= HI) begin
                    good = (good + 1 > LOCK_N) ? LOCK_N : good + 1;
                    if (good == LOCK_N) exp_lock = 1;
                end else begin
                    good     = 0;
                    exp_lock = 0;
                    if (meas < LO) exp_early = 1;
                end
                last_t = n;
            end else if (elapsed == HI) begin
                exp_late = 1;
                good     = 0;
                exp_lock = 0;
            end
`ifdef STUTTER_MON_ERRCNT_EN
            if ((exp_early || exp_late) && exp_err < 255) exp_err++;
`endif
        end
    endtask

    task automatic checkOutput();
        checkValue("lock", 32'(lock), 32'(exp_lock));
        checkValue("early", 32'(early), 32'(exp_early));
        checkValue("late", 32'(late), 32'(exp_late));
        checkValue("interval_vld", 32'(interval_vld), 32'(exp_vld));
        checkValue("interval", 32'(interval), 32'(exp_interval));
`ifdef STUTTER_MON_ERRCNT_EN
        checkValue("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic c);
        reset = r;
        cy_in = c;
        @(posedge clk);
        n++;
        modelStep(r, c);
        #1;
        checkOutput();
    endtask

    task automatic strobeAfter(input int gap);
        for (int i = 1; i < gap; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
    endtask

    initial begin
        int gap;
        $display("[TB] start");

        // Reset, then a long quiet stretch in IDLE.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0);
        checkValue("idle_lock", 32'(lock), 32'd0);
        checkValue("idle_interval", 32'(interval), 32'd0);

        // Four strobes at nominal period: lock after the third.
        strobeAfter(1);
        checkValue("first_no_vld", 32'(interval_vld), 32'd0);
        strobeAfter(8);
        checkValue("s2_lock", 32'(lock), 32'd0);
        strobeAfter(8);
        checkValue("s3_lock", 32'(lock), 32'd1);
        strobeAfter(8);
        checkValue("s4_interval", 32'(interval), 32'd8);
        checkValue("s4_lock", 32'(lock), 32'd1);

        // Early strobe while locked.
        strobeAfter(5);
        checkValue("early_pulse", 32'(early), 32'd1);
        checkValue("early_interval", 32'(interval), 32'd5);
        checkValue("early_lock", 32'(lock), 32'd0);
`ifdef STUTTER_MON_ERRCNT_EN
        checkValue("early_errcnt", 32'(err_cnt), 32'd1);
`endif

        // Relock, then let strobes stop.
        strobeAfter(8);
        strobeAfter(8);
        checkValue("relock", 32'(lock), 32'd1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
        checkValue("late_pulse", 32'(late), 32'd1);
        checkValue("late_lock", 32'(lock), 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
        checkValue("no_repeat_late", 32'(late), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkValue("late_strobe_interval", 32'(interval), 32'd20);
        checkValue("late_strobe_vld", 32'(interval_vld), 32'd1);

        // Tolerance edges 7, 9, 8.
        strobeAfter(7);
        checkValue("tol7_early", 32'(early), 32'd0);
        strobeAfter(9);
        checkValue("tol9_late", 32'(late), 32'd0);
        checkValue("tol9_lock", 32'(lock), 32'd1);
        strobeAfter(8);
        checkValue("tol8_lock", 32'(lock), 32'd1);

        // One-cycle reset while locked.
        applyStimulus(1'b0, 1'b0);
        checkValue("rst_lock", 32'(lock), 32'd0);
        strobeAfter(3);
        checkValue("rst_first_vld", 32'(interval_vld), 32'd0);
        strobeAfter(8);
        checkValue("rst_second_interval", 32'(interval), 32'd8);

        // Random gaps, including saturating ones and occasional resets.
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 29) == 0) applyStimulus(1'b0, 1'b0);
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(15, 40);
            else gap = $urandom_range(1, 12);
            strobeAfter(gap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stutter_monitor.md
Name: stutter_monitor

Overview:
- Receive-side companion to the team's free-running carry/tick generators (16-bit wrap counter producing a 1-cycle `cy` strobe).
- Consumes a strobe stream and measures the interval between strobes. Checks each interval against an expected period and declares lock after N consecutive good intervals.
- Flags early and late (missing) strobes.
- Sits beside any tick consumer as a health check / divider-verification block.

Parameters:
- PERIOD, 65536: expected strobe interval in clk cycles (a strobe at cycle t means the next is due at t+PERIOD); must be >= 4.
- TOL, 0: allowed deviation in cycles; an interval is good iff PERIOD-TOL <= interval <= PERIOD+TOL; TOL < PERIOD/2.
- LOCK_N, 4: consecutive good intervals required to assert lock; 1..15.
- CW, 17: interval counter width; must hold PERIOD+TOL+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (low during a rising clk edge resets the block).
- cy_in  in  1  strobe under test; 1-cycle-high pulse, synchronous to clk.
- lock  out  1  high while locked.
- early  out  1  1-cycle pulse: strobe arrived with interval < PERIOD-TOL.
- late  out  1  1-cycle pulse: no strobe by interval PERIOD+TOL.
- interval  out  CW  last measured strobe-to-strobe interval in cycles (held until the next strobe).
- interval_vld  out  1  1-cycle pulse when interval updates.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, cnt=0, good=0. All outputs are 0, interval=0. Reset mid-operation discards all history; the next strobe is treated as the first.
- All outputs are registered. The response to a strobe at edge t is visible after edge t (1-cycle latency).
- cnt: cleared to 0 on the edge sampling cy_in=1; otherwise increments. Saturates at all-ones and never wraps.
- Measured value on a strobe: meas = cnt+1 (the interval in cycles).
- States:
  - IDLE: wait for the first cy_in. On cy_in: clear cnt, go to TRACK. No interval_vld is issued (no prior reference).
  - TRACK: on cy_in, register interval=meas and pulse interval_vld.
    - If meas is good: good=good+1, saturating at LOCK_N.
    - If meas < PERIOD-TOL: pulse early, good=0.
    - When good reaches LOCK_N, go to LOCKED (lock rises the same edge).
  - LOCKED: same measurement rules. Any early or late sets good=0 and returns to TRACK; lock drops on that same edge.
- Late detection applies in TRACK or LOCKED. When cy_in==0 and cnt+1 == PERIOD+TOL, pulse late once. good=0. State goes to TRACK if LOCKED; otherwise stays in TRACK. No repeat pulses while the strobe stays absent.
- A strobe arriving after late was flagged: register interval (saturated if applicable) and pulse interval_vld. It is not good; good stays 0 and counting restarts.
- Simultaneous cy_in=1 and the late-threshold cycle: the strobe wins. meas = PERIOD+TOL is good and late is not pulsed.
- Back-to-back strobes (cy_in high on consecutive cycles): meas=1, so early pulses (given PERIOD >= 4).
- interval is zero-extended from cnt. With defaults, CW=17 so 65536 fits.

Optional Feature:
- Macro: STUTTER_MON_ERRCNT_EN.
- Defined: adds output err_cnt [7:0]. It increments on every early or late pulse and saturates at 255. It clears only on reset.
- Undefined: port and logic are absent; nothing else changes.

Decomposition:
- Package stutter_pkg:
  - typedef enum logic [1:0] {IDLE, TRACK, LOCKED} mon_state_t
  - localparam default STUTTER_PERIOD = 65536, shared with the generator.
  - function clog2-based counter-width helper.
- One natural sub-module: interval_counter. It is a saturating CW-bit up-counter with sync clear, active-low sync reset and a terminal-compare output. Everything else lives in stutter_monitor.

Test Plan:
All scenarios use PERIOD=8, TOL=1, LOCK_N=2.
- Reset release, cy_in held 0 for 50 cycles -> stays IDLE; lock/early/late/interval_vld all 0; interval=0.
- Strobes every 8 cycles, 4 strobes -> interval_vld pulses after strobes 2, 3, 4 with interval=8. lock rises the cycle after strobe 3 and stays high.
- While locked, next strobe after 5 cycles -> early pulses 1 cycle, interval=5, lock drops the same cycle. err_cnt=1 if STUTTER_MON_ERRCNT_EN.
- While locked, strobes stop -> late pulses once exactly 9 cycles after the last strobe, lock drops, no further late. A strobe at cycle 20 gives interval=20 and does not relock.
- Intervals 7, 9, 8 (tolerance edges) -> all good, no early/late, lock after the second good interval. Strobe landing exactly on cycle 9 produces no late.
- Reset asserted (low) mid-LOCKED for 1 cycle -> lock=0 next cycle, back to IDLE; the first post-reset strobe yields no interval_vld.
